// File: rtl/uart_rx_sipo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_sipo                                                  |
// | Purpose  : Oversampling UART receive front end. Validates the start bit, |
// |            shifts in one frame LSB first and presents it in parallel     |
// |            with a one-clock received pulse.                              |
// | Option   : UART_RX_MAJORITY_EN - 2-of-3 vote around the sample point.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  data_tx,
    output logic                  active_flag,
    output logic                  recieved_flag,
    output logic [FRAME_BITS-1:0] data_parll
);

    localparam int                c_TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_SP        = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]          c_STOP_IDX  = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_FRAME = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   data_parll_q, data_parll_d;

    logic [c_TICK_W-1:0]     w_tick_nxt;
    logic                    w_decide;
    logic                    w_bit;

    // The counter value the current tick moves to; bit timing is referenced to it.
    assign w_tick_nxt = (tick_cnt_q == c_TICK_LAST) ? '0 : tick_cnt_q + 1'b1;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_TICK_W-1:0] c_SP_M1 = c_TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [c_TICK_W-1:0] c_SP_P1 = c_TICK_W'(OVERSAMPLE / 2);

    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (baud_tick && (state_q == S_START || state_q == S_FRAME)) begin
            if (w_tick_nxt == c_SP_M1) vote_d[0] = data_tx;
            if (w_tick_nxt == c_SP)    vote_d[1] = data_tx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) vote_q <= '0;
        else       vote_q <= vote_d;
    end

    assign w_decide = (w_tick_nxt == c_SP_P1);
    assign w_bit    = (vote_q[0] & vote_q[1]) | (vote_q[0] & data_tx) | (vote_q[1] & data_tx);
`else
    assign w_decide = (w_tick_nxt == c_SP);
    assign w_bit    = data_tx;
`endif

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_parll_d = data_parll_q;

        case (state_q)
            S_IDLE: begin
                if (baud_tick && !data_tx) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    tick_cnt_d = w_tick_nxt;
                    if (w_decide) begin
                        if (w_bit) begin
                            // Start bit did not hold low: treat as line glitch.
                            state_d    = S_IDLE;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            shift_d   = {1'b0, shift_q[FRAME_BITS-2:1]};
                            bit_cnt_d = 4'd1;
                        end
                    end else if (tick_cnt_q == c_TICK_LAST) begin
                        state_d = S_FRAME;
                    end
                end
            end

            S_FRAME: begin
                if (baud_tick) begin
                    tick_cnt_d = w_tick_nxt;
                    if (w_decide) begin
                        if (bit_cnt_q == c_STOP_IDX) begin
                            // Publish on the stop sample so data is valid alongside the flag.
                            data_parll_d = {w_bit, shift_q};
                            state_d      = S_DONE;
                        end else begin
                            shift_d   = {w_bit, shift_q[FRAME_BITS-2:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '1;
            data_parll_q <= '1;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_parll_q <= data_parll_d;
        end
    end

    assign active_flag   = (state_q != S_IDLE);
    assign recieved_flag = (state_q == S_DONE);
    assign data_parll    = data_parll_q;

endmodule
`default_nettype wire
